// File: rtl/pwm_pkg.sv
// Shared types and helpers for the RGB PWM driver.
// Duty values are percentages held in 7-bit shadows (0..100).
package pwm_pkg;

  localparam int unsigned PWM_LEVELS = 100;
  localparam int unsigned DUTY_W     = 7;

  typedef logic [DUTY_W-1:0] duty_t;

  // Saturate a signed percentage into the 0..100 range.
  function automatic duty_t clamp_duty(input int duty);
    duty_t result;
    if (duty < 0) begin
      result = '0;
    end else if (duty > int'(PWM_LEVELS)) begin
      result = DUTY_W'(PWM_LEVELS);
    end else begin
      result = DUTY_W'(duty);
    end
    return result;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM colour channel: shadow duty register, level compare, registered pin.
// The pin is forced off whenever en is low.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic [DUTY_W-1:0] lc,
  input  logic [DUTY_W-1:0] duty,
  output logic              led
);

  logic [DUTY_W-1:0] r_shadow;
  logic              r_led;
  logic              w_on;

  assign w_on = (lc < r_shadow);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_led    <= ACTIVE_LOW;
    end else begin
      if (load) begin
        r_shadow <= duty;
      end
      r_led <= (w_on & en) ^ ACTIVE_LOW;
    end
  end

  assign led = r_led;

endmodule

// File: rtl/pwm_rgb_driver.sv
// Three-channel RGB PWM driver with period-boundary duty capture.
// Owns the prescaler, the level counter and the period_start pulse.
module pwm_rgb_driver
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE   = 120,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic signed [31:0] duty_r,
  input  logic signed [31:0] duty_g,
  input  logic signed [31:0] duty_b,
  output logic               led_r,
  output logic               led_g,
  output logic               led_b,
  output logic               period_start
);

  localparam int unsigned PC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PC_W-1:0]   PC_LAST = PC_W'(PRESCALE - 1);
  localparam logic [DUTY_W-1:0] LC_LAST = DUTY_W'(PWM_LEVELS - 1);

  logic [PC_W-1:0]   r_pc;
  logic [DUTY_W-1:0] r_lc;
  logic              r_period_start;

  logic              w_pc_last;
  logic              w_boundary;
  logic              w_load;
  logic [DUTY_W-1:0] w_duty_r;
  logic [DUTY_W-1:0] w_duty_g;
  logic [DUTY_W-1:0] w_duty_b;

  assign w_pc_last  = (r_pc == PC_LAST);
  assign w_boundary = en & w_pc_last & (r_lc == LC_LAST);
  // While disabled the shadows track the inputs so the first enabled period uses them.
  assign w_load     = ~en | w_boundary;

  assign w_duty_r = clamp_duty(int'(duty_r));
  assign w_duty_g = clamp_duty(int'(duty_g));
  assign w_duty_b = clamp_duty(int'(duty_b));

  // Prescaler and level counter; both held at zero while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
      r_lc <= '0;
    end else if (!en) begin
      r_pc <= '0;
      r_lc <= '0;
    end else if (w_pc_last) begin
      r_pc <= '0;
      r_lc <= (r_lc == LC_LAST) ? '0 : r_lc + DUTY_W'(1);
    end else begin
      r_pc <= r_pc + PC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period_start <= 1'b0;
    end else begin
      r_period_start <= w_boundary;
    end
  end

  assign period_start = r_period_start;

  pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_ch_r (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .load (w_load),
    .lc   (r_lc),
    .duty (w_duty_r),
    .led  (led_r)
  );

  pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_ch_g (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .load (w_load),
    .lc   (r_lc),
    .duty (w_duty_g),
    .led  (led_g)
  );

  pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_ch_b (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .load (w_load),
    .lc   (r_lc),
    .duty (w_duty_b),
    .led  (led_b)
  );

endmodule

// File: tb/tb_pwm_rgb_driver.sv
// Scoreboard bench for pwm_rgb_driver (PRESCALE=2, active-low pins).
// Stimulus queues per-cycle expected pin vectors; a negedge monitor pops and compares.
module tb_pwm_rgb_driver;

  logic               clk;
  logic               rst_n;
  logic               en;
  logic signed [31:0] duty_r;
  logic signed [31:0] duty_g;
  logic signed [31:0] duty_b;
  logic               led_r;
  logic               led_g;
  logic               led_b;
  logic               period_start;

  pwm_rgb_driver #(.PRESCALE(2), .ACTIVE_LOW(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .duty_r      (duty_r),
    .duty_g      (duty_g),
    .duty_b      (duty_b),
    .led_r       (led_r),
    .led_g       (led_g),
    .led_b       (led_b),
    .period_start(period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] val;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   cyc     = 0;
  int   base    = 0;
  int   n_pass  = 0;
  int   n_check = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // {led_r, led_g, led_b, period_start} with pins active-low
  function automatic logic [3:0] pat(input bit r_on, input bit g_on, input bit b_on, input bit ps);
    return {~r_on, ~g_on, ~b_on, ps};
  endfunction

  task automatic check(input string tag, input int t, input logic [3:0] act, input logic [3:0] exp_v);
    n_check++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s t=%0d: rgb/ps got %b expected %b", tag, t, act, exp_v);
  endtask

  task automatic push(input int t, input logic [3:0] v, input string tag);
    exp_t e;
    e.cyc = base + t;
    e.val = v;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic wait_to(input int t);
    while (cyc < base + t) @(negedge clk);
  endtask

  // Monitor: outputs are sampled once per cycle at the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        exp_t s;
        s = q.pop_front();
        n_check++;
        $display("FAIL %s: expectation for cycle %0d never sampled", s.tag, s.cyc - base);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        exp_t e;
        e = q.pop_front();
        check(e.tag, e.cyc - base, {led_r, led_g, led_b, period_start}, e.val);
      end
    end
  end

  // Hand-derived shadow duty per period for the run started from reset.
  int sr[6] = '{0, 25, 25, 25, 50, 10};
  int sg[6] = '{0, 100, 100, 100, 100, 0};
  int sb[6] = '{0, 0, 0, 0, 100, 100};

  initial begin
    rst_n  = 1'b0;
    en     = 1'b1;
    duty_r = 25;
    duty_g = 100;
    duty_b = -7;
    repeat (3) @(negedge clk);
    check("reset_state", 0, {led_r, led_g, led_b, period_start}, 4'b1110);
    rst_n = 1'b1;
    base  = cyc;

    // Period p covers cycles 200p+1..200p+200 on the pins; on for the first 2*duty cycles.
    for (int t = 1; t <= 1100; t++) begin
      int p;
      int ph;
      p  = (t - 1) / 200;
      ph = (t - 1) % 200;
      push(t, pat(ph < 2 * sr[p], ph < 2 * sg[p], ph < 2 * sb[p], (t % 200) == 0), "steady");
    end
    for (int t = 1101; t <= 1250; t++) push(t, 4'b1110, "disabled");
    for (int t = 1251; t <= 1450; t++)
      push(t, pat(t <= 1310, 1'b0, 1'b1, t == 1450), "en_rise");

    wait_to(700);
    duty_r = 50;
    duty_b = 250;
    wait_to(840);
    duty_r = 10;
    duty_g = 0;
    duty_b = 100;
    wait_to(1100);
    en = 1'b0;
    wait_to(1150);
    duty_r = 30;
    wait_to(1250);
    en = 1'b1;

    wait_to(1460);
    check("pre_reset", 1460, {led_r, led_g, led_b, period_start}, 4'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 1460, {led_r, led_g, led_b, period_start}, 4'b1110);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base  = cyc;
    for (int t = 1; t <= 260; t++)
      push(t, pat(t >= 201, 1'b0, t >= 201, t == 200), "after_reset");
    wait_to(262);

    if (q.size() != 0) begin
      n_check++;
      $display("FAIL drain: %0d expectations left unchecked", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
